// File: rtl/mixer4_if.sv
// Voice/gain inputs and mixed-sample outputs of the four-channel mixer.
// master drives frames and voices in; slave is the mixer itself.
interface mixer4_if #(
  parameter int BITSIZE  = 24,
  parameter int GAINBITS = 8
);
  logic                       lrclk;
  logic signed [BITSIZE-1:0]  in_1;
  logic signed [BITSIZE-1:0]  in_2;
  logic signed [BITSIZE-1:0]  in_3;
  logic signed [BITSIZE-1:0]  in_4;
  logic [GAINBITS-1:0]        gain_1;
  logic [GAINBITS-1:0]        gain_2;
  logic [GAINBITS-1:0]        gain_3;
  logic [GAINBITS-1:0]        gain_4;
  logic signed [BITSIZE-1:0]  out;
  logic                       out_valid;
  logic                       clip;
  logic                       busy;
  logic                       overrun;

  modport master (
    output lrclk, in_1, in_2, in_3, in_4, gain_1, gain_2, gain_3, gain_4,
    input  out, out_valid, clip, busy, overrun
  );

  modport slave (
    input  lrclk, in_1, in_2, in_3, in_4, gain_1, gain_2, gain_3, gain_4,
    output out, out_valid, clip, busy, overrun
  );
endinterface

// File: rtl/mixer4.sv
// Four-channel gain-weighted mixer: latch on lrclk rise, 4-cycle MAC, saturate.
// Latency 5 bclk from edge to out_valid; no backpressure, edges while busy are dropped and flag overrun.
module mixer4 #(
  parameter int BITSIZE  = 24,
  parameter int GAINBITS = 8
) (
  input  logic     bclk,
  input  logic     reset,
  mixer4_if.slave  bus
);
  localparam int PW = BITSIZE + GAINBITS + 1;
  localparam int AW = BITSIZE + GAINBITS + 3;
  localparam logic signed [AW-1:0] MAXV = {{(AW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic                       lr_d;
  logic                       frame_edge;
  logic [1:0]                 k;
  logic signed [BITSIZE-1:0]  in_sh   [4];
  logic [GAINBITS-1:0]        gain_sh [4];
  logic signed [AW-1:0]       acc;
  logic signed [PW-1:0]       a_ext;
  logic signed [PW-1:0]       g_ext;
  logic signed [PW-1:0]       prod;
  logic signed [AW-1:0]       shifted;
  logic signed [BITSIZE-1:0]  sat;
  logic                       sat_hit;
  logic                       latch;
  logic                       mac_en;
  logic                       out_en;
  logic signed [BITSIZE-1:0]  out_q;
  logic                       out_valid_q;
  logic                       clip_q;
  logic                       busy_q;
  logic                       overrun_q;

  assign frame_edge = bus.lrclk & ~lr_d;

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign a_ext   = PW'(in_sh[k]);
  assign g_ext   = PW'($signed({1'b0, gain_sh[k]}));
  assign prod    = a_ext * g_ext;
  assign shifted = acc >>> (GAINBITS - 1);

  always_comb begin
    sat     = shifted[BITSIZE-1:0];
    sat_hit = 1'b0;
    if (shifted > MAXV) begin
      sat     = MAXV[BITSIZE-1:0];
      sat_hit = 1'b1;
    end else if (shifted < MINV) begin
      sat     = MINV[BITSIZE-1:0];
      sat_hit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    mac_en    = 1'b0;
    out_en    = 1'b0;
    case (state)
      IDLE: if (frame_edge) begin
        latch     = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (k == 2'd3) state_nxt = OUT;
      end
      OUT: begin
        out_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // lr_d resets high so a level already high at release is not seen as an edge.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      lr_d        <= 1'b1;
      k           <= 2'd0;
      acc         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        in_sh[i]   <= '0;
        gain_sh[i] <= '0;
      end
    end else begin
      lr_d        <= bus.lrclk;
      busy_q      <= (state != IDLE);
      out_valid_q <= out_en;
      clip_q      <= out_en & sat_hit;
      if (frame_edge && state != IDLE) overrun_q <= 1'b1;
      if (latch) begin
        in_sh[0]   <= bus.in_1;
        in_sh[1]   <= bus.in_2;
        in_sh[2]   <= bus.in_3;
        in_sh[3]   <= bus.in_4;
        gain_sh[0] <= bus.gain_1;
        gain_sh[1] <= bus.gain_2;
        gain_sh[2] <= bus.gain_3;
        gain_sh[3] <= bus.gain_4;
        acc        <= '0;
        k          <= 2'd0;
      end
      if (mac_en) begin
        acc <= acc + AW'(prod);
        k   <= k + 2'd1;
      end
      if (out_en) out_q <= sat;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.clip      = clip_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_mixer4.sv
// Scoreboard bench for mixer4: expected samples are queued at each accepted frame edge
// and matched against every out_valid pulse, including its cycle.
module tb_mixer4;
  localparam int BS = 24;
  localparam int GB = 8;

  typedef struct {
    logic signed [BS-1:0] o;
    logic                 c;
    longint               cy;
  } exp_t;

  logic   bclk = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  exp_t   sb[$];

  mixer4_if #(.BITSIZE(BS), .GAINBITS(GB)) bus ();

  mixer4 #(.BITSIZE(BS), .GAINBITS(GB)) dut (
    .bclk  (bclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference mix of the voices currently on the bus: sum, floor-divide by unity, clamp.
  function automatic exp_t model(input longint cy);
    exp_t   e;
    longint s;
    longint r;
    s = longint'(bus.in_1) * longint'(bus.gain_1) + longint'(bus.in_2) * longint'(bus.gain_2)
      + longint'(bus.in_3) * longint'(bus.gain_3) + longint'(bus.in_4) * longint'(bus.gain_4);
    r = s >>> (GB - 1);
    e.c = 1'b0;
    if (r > 64'sd8388607) begin
      r = 64'sd8388607;
      e.c = 1'b1;
    end else if (r < -64'sd8388608) begin
      r = -64'sd8388608;
      e.c = 1'b1;
    end
    e.o  = r[BS-1:0];
    e.cy = cy;
    return e;
  endfunction

  always @(negedge bclk) begin
    if (!reset && bus.out_valid) begin
      check("valid_expected", longint'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cy);
        check("out", longint'(bus.out), longint'(e.o));
        check("clip", longint'(bus.clip), longint'(e.c));
      end
    end
  end

  task automatic set_in(input int a, input int b, input int c, input int d,
                        input int ga, input int gb, input int gc, input int gd);
    bus.in_1 = a[BS-1:0];  bus.in_2 = b[BS-1:0];
    bus.in_3 = c[BS-1:0];  bus.in_4 = d[BS-1:0];
    bus.gain_1 = ga[GB-1:0]; bus.gain_2 = gb[GB-1:0];
    bus.gain_3 = gc[GB-1:0]; bus.gain_4 = gd[GB-1:0];
  endtask

  // One lrclk rise; the pulse must appear 5 cycles after the detecting edge.
  task automatic do_frame(input string tag);
    @(negedge bclk);
    bus.lrclk = 1'b1;
    sb.push_back(model(cyc + 6));
    @(negedge bclk);
    bus.lrclk = 1'b0;
    repeat (7) @(negedge bclk);
    check({tag, "_drained"}, longint'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.lrclk = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge bclk);
    check("rst_out", longint'(bus.out), 0);
    check("rst_valid", longint'(bus.out_valid), 0);
    check("rst_clip", longint'(bus.clip), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_overrun", longint'(bus.overrun), 0);
    reset = 1'b0;
    repeat (2) @(negedge bclk);

    // Unity passthrough with busy window and out hold
    set_in(1000, 0, 0, 0, 128, 0, 0, 0);
    @(negedge bclk);
    bus.lrclk = 1'b1;
    sb.push_back(model(cyc + 6));
    @(negedge bclk);
    bus.lrclk = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge bclk);
      check($sformatf("busy_t%0d", i), longint'(bus.busy), (i <= 5) ? 1 : 0);
    end
    check("valid_low_t6", longint'(bus.out_valid), 0);
    check("out_hold", longint'(bus.out), 1000);
    repeat (2) @(negedge bclk);
    check("pass_drained", longint'(sb.size()), 0);

    // Summation; in_1 changes mid-mix without affecting it
    set_in(100, 200, 300, 400, 128, 128, 128, 128);
    @(negedge bclk);
    bus.lrclk = 1'b1;
    sb.push_back(model(cyc + 6));
    @(negedge bclk);
    bus.lrclk = 1'b0;
    @(negedge bclk);
    bus.in_1 = 24'sd5000;
    repeat (7) @(negedge bclk);
    check("sum_drained", longint'(sb.size()), 0);
    do_frame("sum_next");

    // Scaling and floor rounding
    set_in(-1000, 0, 0, 0, 64, 0, 0, 0);  do_frame("half_neg");
    set_in(-1, 0, 0, 0, 64, 0, 0, 0);     do_frame("floor_m1");
    set_in(1, 0, 0, 0, 64, 0, 0, 0);      do_frame("floor_p1");
    set_in(12345, -777, 4000, -1, 200, 17, 0, 255); do_frame("mixed");

    // Saturation both ways, then clean
    set_in(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 255, 255, 255, 255);
    do_frame("sat_pos");
    set_in(-8388608, -8388608, -8388608, -8388608, 255, 255, 255, 255);
    do_frame("sat_neg");
    set_in(42, 0, 0, 0, 128, 0, 0, 0);
    do_frame("unclip");

    // Overrun: second edge at t+2 dropped, edge at t+6 accepted
    set_in(300, 0, 0, 0, 128, 0, 0, 0);
    check("ovr_before", longint'(bus.overrun), 0);
    @(negedge bclk);
    bus.lrclk = 1'b1;
    sb.push_back(model(cyc + 6));
    @(negedge bclk);
    bus.lrclk = 1'b0;
    @(negedge bclk);
    bus.lrclk = 1'b1;
    @(negedge bclk);
    bus.lrclk = 1'b0;
    check("ovr_set", longint'(bus.overrun), 1);
    repeat (3) @(negedge bclk);
    set_in(-600, 0, 0, 0, 128, 0, 0, 0);
    bus.lrclk = 1'b1;
    sb.push_back(model(cyc + 6));
    @(negedge bclk);
    bus.lrclk = 1'b0;
    repeat (7) @(negedge bclk);
    check("ovr_drained", longint'(sb.size()), 0);
    check("ovr_sticky", longint'(bus.overrun), 1);

    // Reset mid-MAC aborts the frame; held-high lrclk does not retrigger
    set_in(2222, 0, 0, 0, 128, 0, 0, 0);
    @(negedge bclk);
    bus.lrclk = 1'b1;
    @(negedge bclk);
    repeat (2) @(negedge bclk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", longint'(bus.busy), 0);
    check("rst_mid_out", longint'(bus.out), 0);
    check("rst_mid_overrun", longint'(bus.overrun), 0);
    repeat (2) @(negedge bclk);
    reset = 1'b0;
    repeat (8) @(negedge bclk);
    check("rst_no_restart", longint'(bus.busy), 0);
    bus.lrclk = 1'b0;
    set_in(-3333, 10, 0, 0, 128, 128, 0, 0);
    do_frame("after_rst");
    check("after_rst_ovr", longint'(bus.overrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
